// File: rtl/crc_lut_stream.sv
// Streaming CRC-32 (MSB-first, non-reflected) using elaboration-time slicing tables.
// Full beats fold in one cycle; a short last beat drains one byte per cycle.
module crc_lut_stream #(
  parameter int unsigned BYTES  = 4,
  parameter logic [31:0] POLY   = 32'h04C11DB7,
  parameter logic [31:0] INIT   = 32'hFFFFFFFF,
  parameter logic [31:0] XOROUT = 32'hFFFFFFFF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [8*BYTES-1:0]         in_data,
  input  logic                       in_sop,
  input  logic                       in_last,
  input  logic [$clog2(BYTES+1)-1:0] in_bytes,
  output logic                       crc_valid,
  output logic [31:0]                crc_out
);

  localparam int unsigned DW = 8 * BYTES;
  localparam int unsigned CW = $clog2(BYTES + 1);
  localparam int unsigned PW = (DW > 32) ? DW : 32;
  localparam int unsigned SH = (BYTES < 4) ? DW : 0;

  typedef enum logic [1:0] {IDLE, RUN, TAIL} state_t;

  // Remainder of byte b followed by k zero bytes.
  function automatic logic [31:0] tab_entry(input int k, input int b);
    logic [31:0] c;
    c = {8'(b), 24'h0};
    for (int i = 0; i < 8 * (k + 1); i++) begin
      c = c[31] ? ((c << 1) ^ POLY) : (c << 1);
    end
    return c;
  endfunction

  logic [31:0] tab [BYTES][256];

  for (genvar k = 0; k < BYTES; k++) begin : g_tab
    for (genvar b = 0; b < 256; b++) begin : g_ent
      assign tab[k][b] = tab_entry(k, b);
    end
  end

  state_t          state_q, state_d;
  logic [31:0]     crc_q, crc_d;
  logic [31:0]     crc_out_d;
  logic            crc_valid_d;
  logic [DW-1:0]   tail_data_q, tail_data_d;
  logic [CW-1:0]   tail_cnt_q, tail_cnt_d;
  logic [31:0]     base;
  logic [31:0]     full_fold;
  logic [31:0]     tail_fold;
  logic [PW-1:0]   mix;
  logic            accept;
  logic            full_last;

  assign in_ready  = (state_q != TAIL);
  assign accept    = in_valid && in_ready;
  assign full_last = (in_bytes == '0) || (in_bytes >= CW'(BYTES));
  // A beat with sop, or any beat arriving in IDLE, starts from INIT.
  assign base      = (in_sop || state_q == IDLE) ? INIT : crc_q;

  // Working CRC overlays the leading data bytes; each byte then indexes the
  // table matching its distance from the end of the beat.
  always_comb begin
    mix       = (PW'(base) << (PW - 32)) ^ (PW'(in_data) << (PW - DW));
    full_fold = (BYTES < 4) ? (base << SH) : 32'h0;
    for (int j = 0; j < int'(BYTES); j++) begin
      full_fold = full_fold ^ tab[int'(BYTES) - 1 - j][mix[PW - 1 - 8 * j -: 8]];
    end
  end

  assign tail_fold = (crc_q << 8) ^ tab[0][crc_q[31:24] ^ tail_data_q[DW-1 -: 8]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      crc_q       <= INIT;
      crc_out     <= 32'h0;
      crc_valid   <= 1'b0;
      tail_data_q <= '0;
      tail_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      crc_out     <= crc_out_d;
      crc_valid   <= crc_valid_d;
      tail_data_q <= tail_data_d;
      tail_cnt_q  <= tail_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    crc_out_d   = crc_out;
    crc_valid_d = 1'b0;
    tail_data_d = tail_data_q;
    tail_cnt_d  = tail_cnt_q;
    case (state_q)
      IDLE, RUN: begin
        if (accept) begin
          if (!in_last) begin
            crc_d   = full_fold;
            state_d = RUN;
          end else if (full_last) begin
            crc_out_d   = full_fold ^ XOROUT;
            crc_valid_d = 1'b1;
            crc_d       = INIT;
            state_d     = IDLE;
          end else begin
            crc_d       = base;
            tail_data_d = in_data;
            tail_cnt_d  = in_bytes;
            state_d     = TAIL;
          end
        end
      end
      TAIL: begin
        tail_data_d = tail_data_q << 8;
        tail_cnt_d  = tail_cnt_q - CW'(1);
        if (tail_cnt_q == CW'(1)) begin
          crc_out_d   = tail_fold ^ XOROUT;
          crc_valid_d = 1'b1;
          crc_d       = INIT;
          state_d     = IDLE;
        end else begin
          crc_d = tail_fold;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_crc_lut_stream.sv
// Directed bench for crc_lut_stream at BYTES=4 (two XOROUT settings), BYTES=1 and BYTES=16.
module tb_crc_lut_stream;

  localparam logic [31:0] CHECK     = 32'hFC891918;
  localparam logic [31:0] CHECK_RAW = 32'h0376E6E7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // BYTES=4 pair (shared inputs)
  logic        v4 = 0, s4 = 0, l4 = 0;
  logic [31:0] d4 = '0;
  logic [2:0]  b4 = '0;
  logic        r4, cv4, rx, cvx;
  logic [31:0] co4, cox;
  // BYTES=1
  logic        v1 = 0, s1 = 0, l1 = 0;
  logic [7:0]  d1 = '0;
  logic [0:0]  b1 = '0;
  logic        r1, cv1;
  logic [31:0] co1;
  // BYTES=16
  logic         v16 = 0, s16 = 0, l16 = 0;
  logic [127:0] d16 = '0;
  logic [4:0]   b16 = '0;
  logic         r16, cv16;
  logic [31:0]  co16;

  int n_vec = 0;
  int n_bad = 0;
  int p4 = 0;
  int p16 = 0;
  logic [7:0] msg [16];

  crc_lut_stream #(.BYTES(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(r4), .in_data(d4), .in_sop(s4),
    .in_last(l4), .in_bytes(b4), .crc_valid(cv4), .crc_out(co4));
  crc_lut_stream #(.BYTES(4), .XOROUT(32'h0)) u4x (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(rx), .in_data(d4), .in_sop(s4),
    .in_last(l4), .in_bytes(b4), .crc_valid(cvx), .crc_out(cox));
  crc_lut_stream #(.BYTES(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1), .in_data(d1), .in_sop(s1),
    .in_last(l1), .in_bytes(b1), .crc_valid(cv1), .crc_out(co1));
  crc_lut_stream #(.BYTES(16)) u16 (
    .clk(clk), .rst(rst), .in_valid(v16), .in_ready(r16), .in_data(d16), .in_sop(s16),
    .in_last(l16), .in_bytes(b16), .crc_valid(cv16), .crc_out(co16));

  always @(posedge clk) begin
    if (cv4)  p4  <= p4 + 1;
    if (cv16) p16 <= p16 + 1;
  end

  // Bit-serial reference over msg[0..n-1], final XOR 32'hFFFFFFFF.
  function automatic logic [31:0] ref_crc(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {msg[i], 24'h0};
      for (int b = 0; b < 8; b++) c = c[31] ? ((c << 1) ^ 32'h04C11DB7) : (c << 1);
    end
    return c ^ 32'hFFFFFFFF;
  endfunction

  task automatic beat4(input logic [31:0] d, input logic sop, input logic last, input logic [2:0] nb);
    d4 = d; s4 = sop; l4 = last; b4 = nb; v4 = 1'b1;
    @(posedge clk); #1;
    v4 = 1'b0; s4 = 1'b0; l4 = 1'b0;
  endtask

  task automatic beat1(input logic [7:0] d, input logic sop, input logic last);
    d1 = d; s1 = sop; l1 = last; b1 = 1'b0; v1 = 1'b1;
    @(posedge clk); #1;
    v1 = 1'b0; s1 = 1'b0; l1 = 1'b0;
  endtask

  task automatic gap(input int maxn);
    int n;
    n = $urandom_range(0, maxn);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    n_vec++; if (cv4 !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", cv4); end
    n_vec++; if (co4 !== 32'h0) begin n_bad++; $display("FAIL reset_crc got %h want 0", co4); end
    n_vec++; if (r4 !== 1'b1 || rx !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b%b want 11", r4, rx); end
    n_vec++; if (r1 !== 1'b1 || r16 !== 1'b1) begin n_bad++; $display("FAIL reset_ready_1_16 got %b%b want 11", r1, r16); end
  endtask

  // "1234","5678","9"(k=1) on both XOROUT settings.
  task automatic test_tail_frame();
    beat4(32'h31323334, 1, 0, 0);
    beat4(32'h35363738, 0, 0, 0);
    beat4(32'h39000000, 0, 1, 3'd1);
    n_vec++; if (r4 !== 1'b0 || cv4 !== 1'b0) begin n_bad++; $display("FAIL tail_entry ready/valid got %b/%b want 0/0", r4, cv4); end
    @(posedge clk); #1;
    n_vec++; if (cv4 !== 1'b1 || co4 !== CHECK) begin n_bad++; $display("FAIL tail_crc got %b/%h want 1/%h", cv4, co4, CHECK); end
    n_vec++; if (cvx !== 1'b1 || cox !== CHECK_RAW) begin n_bad++; $display("FAIL tail_crc_noxor got %b/%h want 1/%h", cvx, cox, CHECK_RAW); end
    @(posedge clk); #1;
    n_vec++; if (cv4 !== 1'b0 || co4 !== CHECK) begin n_bad++; $display("FAIL pulse_width got %b/%h want 0/%h", cv4, co4, CHECK); end
  endtask

  // Short last beats of 2 and 3 bytes: pulse on the k-th edge only.
  task automatic test_tail_lengths();
    for (int k = 2; k <= 3; k++) begin
      for (int i = 0; i < 4 + k; i++) msg[i] = 8'h41 + 8'(i);
      beat4({msg[0], msg[1], msg[2], msg[3]}, 1, 0, 0);
      beat4({msg[4], msg[5], (k == 3) ? msg[6] : 8'hAA, 8'h55}, 0, 1, 3'(k));
      for (int e = 1; e <= k; e++) begin
        @(posedge clk); #1;
        if (e < k) begin
          n_vec++; if (cv4 !== 1'b0 || r4 !== 1'b0) begin n_bad++; $display("FAIL tail%0d_edge%0d valid/ready got %b/%b want 0/0", k, e, cv4, r4); end
        end
      end
      n_vec++; if (cv4 !== 1'b1 || co4 !== ref_crc(4 + k)) begin n_bad++; $display("FAIL tail%0d_crc got %b/%h want 1/%h", k, cv4, co4, ref_crc(4 + k)); end
    end
  endtask

  // Full last beats (in_bytes 0, 7, 4) pulse at the accepting edge, back-to-back.
  task automatic test_full_last();
    logic [2:0] nbs [3];
    logic [31:0] want;
    nbs[0] = 3'd0; nbs[1] = 3'd7; nbs[2] = 3'd4;
    for (int i = 0; i < 8; i++) msg[i] = 8'h31 + 8'(i);
    want = ref_crc(8);
    for (int f = 0; f < 3; f++) begin
      beat4(32'h31323334, 1, 0, 3'd2);
      beat4(32'h35363738, 0, 1, nbs[f]);
      n_vec++; if (cv4 !== 1'b1 || co4 !== want) begin n_bad++; $display("FAIL full_last_nb%0d got %b/%h want 1/%h", nbs[f], cv4, co4, want); end
      n_vec++; if (r4 !== 1'b1) begin n_bad++; $display("FAIL full_last_ready got %b want 1", r4); end
    end
  endtask

  task automatic test_bytes1();
    for (int i = 0; i < 9; i++) begin
      beat1(8'h31 + 8'(i), i == 0, i == 8);
      if (i == 4) gap(3);
    end
    n_vec++; if (cv1 !== 1'b1 || co1 !== CHECK) begin n_bad++; $display("FAIL bytes1_crc got %b/%h want 1/%h", cv1, co1, CHECK); end
  endtask

  task automatic frame16(input string tag);
    d16 = {72'h313233343536373839, 56'h0}; s16 = 1; l16 = 1; b16 = 5'd9; v16 = 1;
    @(posedge clk); #1;
    v16 = 0; s16 = 0; l16 = 0;
    for (int e = 1; e <= 9; e++) begin
      n_vec++; if (r16 !== 1'b0) begin n_bad++; $display("FAIL %s_ready_e%0d got %b want 0", tag, e, r16); end
      @(posedge clk); #1;
      if (e < 9 && cv16 !== 1'b0) begin n_bad++; $display("FAIL %s_early_valid_e%0d got 1 want 0", tag, e); end
    end
    n_vec++; if (cv16 !== 1'b1 || co16 !== CHECK) begin n_bad++; $display("FAIL %s_crc got %b/%h want 1/%h", tag, cv16, co16, CHECK); end
    n_vec++; if (r16 !== 1'b1) begin n_bad++; $display("FAIL %s_ready_after got %b want 1", tag, r16); end
  endtask

  task automatic test_bytes16();
    frame16("bytes16");
  endtask

  // Second sop lands in the crc_valid cycle; random gaps elsewhere.
  task automatic test_back_to_back();
    int p0;
    p0 = p4;
    for (int f = 0; f < 2; f++) begin
      beat4(32'h31323334, 1, 0, 0); gap(2);
      beat4(32'h35363738, 0, 0, 0); gap(2);
      beat4(32'h39000000, 0, 1, 3'd1);
      @(posedge clk); #1;
      n_vec++; if (cv4 !== 1'b1 || co4 !== CHECK) begin n_bad++; $display("FAIL b2b_frame%0d got %b/%h want 1/%h", f, cv4, co4, CHECK); end
    end
    @(posedge clk); #1;
    n_vec++; if (p4 - p0 != 2) begin n_bad++; $display("FAIL b2b_pulses got %0d want 2", p4 - p0); end
  endtask

  task automatic test_hold();
    repeat (3) @(posedge clk);
    #1;
    beat4(32'hDEADBEEF, 1, 0, 0);
    beat4(32'h01020304, 0, 0, 0);
    n_vec++; if (co4 !== CHECK || cv4 !== 1'b0) begin n_bad++; $display("FAIL hold got %b/%h want 0/%h", cv4, co4, CHECK); end
  endtask

  // Partial frames restarted by sop, and an IDLE beat without sop.
  task automatic test_sop_restart();
    beat4(32'h31323334, 1, 0, 0);
    beat4(32'h31323334, 1, 0, 0);
    beat4(32'h35363738, 0, 0, 0);
    beat4(32'h39000000, 0, 1, 3'd1);
    @(posedge clk); #1;
    n_vec++; if (cv4 !== 1'b1 || co4 !== CHECK) begin n_bad++; $display("FAIL sop_restart4 got %b/%h want 1/%h", cv4, co4, CHECK); end
    beat1(8'h31, 1, 0);
    beat1(8'h32, 0, 0);
    for (int i = 0; i < 9; i++) beat1(8'h31 + 8'(i), i == 0, i == 8);
    n_vec++; if (cv1 !== 1'b1 || co1 !== CHECK) begin n_bad++; $display("FAIL sop_restart1 got %b/%h want 1/%h", cv1, co1, CHECK); end
    repeat (2) @(posedge clk);
    #1;
    beat4(32'h31323334, 0, 0, 0);
    beat4(32'h35363738, 0, 0, 0);
    beat4(32'h39000000, 0, 1, 3'd1);
    @(posedge clk); #1;
    n_vec++; if (cv4 !== 1'b1 || co4 !== CHECK) begin n_bad++; $display("FAIL idle_nosop got %b/%h want 1/%h", cv4, co4, CHECK); end
  endtask

  task automatic test_reset_tail();
    int p0;
    d16 = {72'h313233343536373839, 56'h0}; s16 = 1; l16 = 1; b16 = 5'd9; v16 = 1;
    @(posedge clk); #1;
    v16 = 0; s16 = 0; l16 = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #2;
    n_vec++; if (co16 !== 32'h0 || cv16 !== 1'b0) begin n_bad++; $display("FAIL rst_tail_async got %b/%h want 0/0", cv16, co16); end
    @(posedge clk); #1 rst = 1'b0;
    p0 = p16;
    repeat (12) @(posedge clk);
    #1;
    n_vec++; if (p16 != p0 || co16 !== 32'h0) begin n_bad++; $display("FAIL rst_tail_quiet pulses %0d crc %h want 0/0", p16 - p0, co16); end
    n_vec++; if (r16 !== 1'b1) begin n_bad++; $display("FAIL rst_tail_ready got %b want 1", r16); end
    frame16("after_rst");
  endtask

  initial begin
    test_reset();
    test_tail_frame();
    test_tail_lengths();
    test_full_last();
    test_bytes1();
    test_bytes16();
    test_back_to_back();
    test_hold();
    test_sop_restart();
    test_reset_tail();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
